// File: rtl/xbar_pkg.sv
// Shared crossbar types: slave-mux FSM states, master id type and one-hot grant codes.
// The grant codes match the encoding driven by the sibling round_robin arbiter.
package xbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } xbar_state_e;

    typedef logic mst_id_t;

    localparam mst_id_t    MST_M0  = 1'b0;
    localparam mst_id_t    MST_M1  = 1'b1;
    localparam logic [1:0] GRNT_M0 = 2'b01;
    localparam logic [1:0] GRNT_M1 = 2'b10;

endpackage

// File: rtl/xbar_slave_mux_if.sv
// Bus bundle between two masters, the arbiter grant, the slave mux and one shared slave.
// The slave modport is the mux's view; the master modport is the surrounding environment.
interface xbar_slave_mux_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [1:0]        grnt;
    logic              m0_req;
    logic              m1_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic              m0_we;
    logic              m1_we;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_ack;
    logic              m1_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              s_req;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we;
    logic [DATA_W-1:0] s_wdata;
    logic              s_ack;
    logic [DATA_W-1:0] s_rdata;
    logic              busy;
    logic              grnt_err;

    modport slave (
        input  grnt, m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
        input  m0_wdata, m1_wdata, s_ack, s_rdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
        output s_req, s_addr, s_we, s_wdata, busy, grnt_err
    );

    modport master (
        output grnt, m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we,
        output m0_wdata, m1_wdata, s_ack, s_rdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata,
        input  s_req, s_addr, s_we, s_wdata, busy, grnt_err
    );

endinterface

// File: rtl/xbar_slave_mux.sv
// Slave-side mux: captures the granted master's request, owns the slave until completion.
// Define XBAR_MUX_RESP_REG_EN to register ack/rdata back to the master (adds a RESP cycle).
module xbar_slave_mux
    import xbar_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    xbar_slave_mux_if.slave bus
);

    xbar_state_e       state_q;
    mst_id_t           owner_q;
    logic              s_req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              grnt_err_q;

    logic              illegal_s;
    logic              take_m0_s;
    logic              take_m1_s;
    logic              m0_ack_s;
    logic              m1_ack_s;
    logic [DATA_W-1:0] m0_rdata_s;
    logic [DATA_W-1:0] m1_rdata_s;

`ifdef XBAR_MUX_RESP_REG_EN
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata_q;
`endif

    // Grant decode; an illegal 2'b11 grant is resolved in favour of master 0.
    always_comb begin
        illegal_s = (bus.grnt == 2'b11);
        take_m0_s = ((bus.grnt == GRNT_M0) || illegal_s) && bus.m0_req;
        take_m1_s = (bus.grnt == GRNT_M1) && bus.m1_req;
    end

    // Transaction FSM with all slave-facing outputs held in registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            owner_q    <= MST_M0;
            s_req_q    <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            we_q       <= 1'b0;
            wdata_q    <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
            grnt_err_q <= 1'b0;
`ifdef XBAR_MUX_RESP_REG_EN
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata_q    <= {DATA_W{1'b0}};
`endif
        end else begin
            if (illegal_s) begin
                grnt_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (take_m0_s || take_m1_s) begin
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                        s_req_q <= 1'b1;
                        owner_q <= take_m0_s ? MST_M0 : MST_M1;
                        addr_q  <= take_m0_s ? bus.m0_addr  : bus.m1_addr;
                        we_q    <= take_m0_s ? bus.m0_we    : bus.m1_we;
                        wdata_q <= take_m0_s ? bus.m0_wdata : bus.m1_wdata;
                    end
                end
                ST_BUSY: begin
                    // Completion is driven only by the slave; the owner's req is not watched.
                    if (bus.s_ack) begin
                        s_req_q <= 1'b0;
                        addr_q  <= {ADDR_W{1'b0}};
                        we_q    <= 1'b0;
                        wdata_q <= {DATA_W{1'b0}};
`ifdef XBAR_MUX_RESP_REG_EN
                        state_q <= ST_RESP;
                        rdata_q <= bus.s_rdata;
                        ack0_q  <= (owner_q == MST_M0);
                        ack1_q  <= (owner_q == MST_M1);
`else
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
`ifdef XBAR_MUX_RESP_REG_EN
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    rdata_q <= {DATA_W{1'b0}};
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    s_req_q <= 1'b0;
                    addr_q  <= {ADDR_W{1'b0}};
                    we_q    <= 1'b0;
                    wdata_q <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    // Response steering: only the owning master sees ack/rdata, the other stays at zero.
    always_comb begin
        m0_ack_s   = 1'b0;
        m1_ack_s   = 1'b0;
        m0_rdata_s = {DATA_W{1'b0}};
        m1_rdata_s = {DATA_W{1'b0}};
`ifdef XBAR_MUX_RESP_REG_EN
        m0_ack_s   = ack0_q;
        m1_ack_s   = ack1_q;
        m0_rdata_s = ack0_q ? rdata_q : {DATA_W{1'b0}};
        m1_rdata_s = ack1_q ? rdata_q : {DATA_W{1'b0}};
`else
        if ((state_q == ST_BUSY) && bus.s_ack) begin
            m0_ack_s   = (owner_q == MST_M0);
            m1_ack_s   = (owner_q == MST_M1);
            m0_rdata_s = (owner_q == MST_M0) ? bus.s_rdata : {DATA_W{1'b0}};
            m1_rdata_s = (owner_q == MST_M1) ? bus.s_rdata : {DATA_W{1'b0}};
        end else begin
            m0_ack_s   = 1'b0;
            m1_ack_s   = 1'b0;
        end
`endif
    end

    assign bus.m0_ack   = m0_ack_s;
    assign bus.m1_ack   = m1_ack_s;
    assign bus.m0_rdata = m0_rdata_s;
    assign bus.m1_rdata = m1_rdata_s;
    assign bus.s_req    = s_req_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_we     = we_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.busy     = busy_q;
    assign bus.grnt_err = grnt_err_q;

endmodule

// File: tb/tb_xbar_slave_mux.sv
// Self-checking bench for xbar_slave_mux: directed scenarios plus random traffic,
// compared each cycle against a transaction-level reference model.
module tb_xbar_slave_mux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int VW = 3 * DW + AW + 6;
`ifdef XBAR_MUX_RESP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    xbar_slave_mux_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    xbar_slave_mux #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: one transaction record plus its phase.
    bit          md_active;
    bit          md_wait;
    bit          md_resp;
    bit          md_owner;
    logic [AW-1:0] md_addr;
    bit          md_we;
    logic [DW-1:0] md_wdata;
    logic [DW-1:0] md_rdata;
    bit          md_err;

    logic          smp_m0_ack, smp_m1_ack, smp_s_req, smp_s_we, smp_busy, smp_grnt_err;
    logic [DW-1:0] smp_m0_rdata, smp_m1_rdata, smp_s_wdata;
    logic [AW-1:0] smp_s_addr;

    logic [VW-1:0] ev, av;

    task automatic model_reset();
        md_active = 1'b0; md_wait = 1'b0; md_resp = 1'b0; md_owner = 1'b0;
        md_addr = '0; md_we = 1'b0; md_wdata = '0; md_rdata = '0; md_err = 1'b0;
    endtask

    task automatic drive_idle();
        bus.grnt = 2'b00; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_we = 1'b0; bus.m1_we = 1'b0;
        bus.m0_wdata = '0; bus.m1_wdata = '0; bus.s_ack = 1'b0; bus.s_rdata = '0;
    endtask

    // Sample at the falling edge, then advance the model at the rising edge.
    task automatic cycle(output logic [VW-1:0] exp_v, output logic [VW-1:0] act_v);
        bit            ack;
        logic [DW-1:0] rd;
        @(negedge clk);
        ack = 1'b0;
        rd  = '0;
`ifdef XBAR_MUX_RESP_REG_EN
        if (md_resp) begin ack = 1'b1; rd = md_rdata; end
`else
        if (md_wait && bus.s_ack) begin ack = 1'b1; rd = bus.s_rdata; end
`endif
        exp_v = {ack && !md_owner, (ack && !md_owner) ? rd : {DW{1'b0}},
                 ack && md_owner,  (ack && md_owner)  ? rd : {DW{1'b0}},
                 md_wait, md_wait ? md_addr : {AW{1'b0}}, md_wait && md_we,
                 md_wait ? md_wdata : {DW{1'b0}}, md_active, md_err};
        smp_m0_ack = bus.m0_ack;   smp_m0_rdata = bus.m0_rdata;
        smp_m1_ack = bus.m1_ack;   smp_m1_rdata = bus.m1_rdata;
        smp_s_req  = bus.s_req;    smp_s_addr   = bus.s_addr;
        smp_s_we   = bus.s_we;     smp_s_wdata  = bus.s_wdata;
        smp_busy   = bus.busy;     smp_grnt_err = bus.grnt_err;
        act_v = {smp_m0_ack, smp_m0_rdata, smp_m1_ack, smp_m1_rdata, smp_s_req,
                 smp_s_addr, smp_s_we, smp_s_wdata, smp_busy, smp_grnt_err};
        @(posedge clk);
        if (bus.grnt == 2'b11) md_err = 1'b1;
        if (md_active) begin
`ifdef XBAR_MUX_RESP_REG_EN
            if (md_resp) begin
                md_active = 1'b0; md_resp = 1'b0;
            end else if (bus.s_ack) begin
                md_wait = 1'b0; md_resp = 1'b1; md_rdata = bus.s_rdata;
            end
`else
            if (bus.s_ack) begin md_active = 1'b0; md_wait = 1'b0; end
`endif
        end else if (bus.grnt[0] && bus.m0_req) begin
            md_active = 1'b1; md_wait = 1'b1; md_owner = 1'b0;
            md_addr = bus.m0_addr; md_we = bus.m0_we; md_wdata = bus.m0_wdata;
        end else if (bus.grnt == 2'b10 && bus.m1_req) begin
            md_active = 1'b1; md_wait = 1'b1; md_owner = 1'b1;
            md_addr = bus.m1_addr; md_we = bus.m1_we; md_wdata = bus.m1_wdata;
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        drive_idle();
        for (int i = 0; i < n; i++) begin
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL idle act=%h exp=%h", av, ev);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        resetn = 1'b0;
        model_reset();
        #3;
        total_cnt++;
        av = {bus.m0_ack, bus.m0_rdata, bus.m1_ack, bus.m1_rdata, bus.s_req,
              bus.s_addr, bus.s_we, bus.s_wdata, bus.busy, bus.grnt_err};
        if (av !== {VW{1'b0}}) $display("FAIL reset_outputs act=%h exp=0", av);
        else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic_write();
        int ack_at = -1;
        bit m1_seen = 1'b0;
        bus.grnt = 2'b01; bus.m0_req = 1'b1; bus.m0_addr = 32'h10;
        bus.m0_we = 1'b1; bus.m0_wdata = 32'hA5;
        for (int c = 1; c <= 7; c++) begin
            bus.s_ack = (c == 4);
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL basic_model c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
            if (c == 2) begin
                total_cnt++;
                if (smp_s_req !== 1'b1 || smp_s_addr !== 32'h10 || smp_s_wdata !== 32'hA5 || smp_s_we !== 1'b1)
                    $display("FAIL basic_slave_drive req=%b addr=%h wdata=%h we=%b exp 1/10/a5/1",
                             smp_s_req, smp_s_addr, smp_s_wdata, smp_s_we);
                else pass_cnt++;
            end
            if (smp_m1_ack !== 1'b0) m1_seen = 1'b1;
            if (smp_m0_ack === 1'b1 && ack_at < 0) begin
                ack_at = c;
                bus.m0_req = 1'b0; bus.grnt = 2'b00;
            end
        end
        total_cnt++;
        if (ack_at !== 4 + LAT) $display("FAIL basic_ack_cycle act=%0d exp=%0d", ack_at, 4 + LAT);
        else pass_cnt++;
        total_cnt++;
        if (m1_seen) $display("FAIL basic_m1_ack act=1 exp=0");
        else pass_cnt++;
        idle_cycles(2);
    endtask

    task automatic test_read_m1();
        int ack_at = -1;
        bus.grnt = 2'b10; bus.m1_req = 1'b1; bus.m1_addr = 32'h20; bus.m1_we = 1'b0;
        bus.s_rdata = 32'hDEADBEEF;
        for (int c = 1; c <= 6; c++) begin
            bus.s_ack = (c == 3);
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL read_model c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
            if (smp_m1_ack === 1'b1 && ack_at < 0) begin
                ack_at = c;
                total_cnt++;
                if (smp_m1_rdata !== 32'hDEADBEEF || smp_m0_rdata !== 32'h0)
                    $display("FAIL read_rdata m1=%h m0=%h exp deadbeef/0", smp_m1_rdata, smp_m0_rdata);
                else pass_cnt++;
                bus.m1_req = 1'b0; bus.grnt = 2'b00;
            end
        end
        total_cnt++;
        if (ack_at !== 3 + LAT) $display("FAIL read_ack_cycle act=%0d exp=%0d", ack_at, 3 + LAT);
        else pass_cnt++;
        idle_cycles(2);
    endtask

    task automatic test_grant_toggle();
        int m1_start = -1;
        bit addr_bad = 1'b0;
        bus.grnt = 2'b01; bus.m0_req = 1'b1; bus.m0_addr = 32'h40; bus.m0_we = 1'b1;
        bus.m0_wdata = 32'h1234;
        for (int c = 1; c <= 12; c++) begin
            bus.s_ack = (c == 4) || (m1_start > 0 && c == m1_start + 1);
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL toggle_model c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
            if (c == 1) begin
                bus.grnt = 2'b10; bus.m1_req = 1'b1; bus.m1_addr = 32'h30; bus.m1_we = 1'b0;
            end
            if ((c == 2 || c == 3) && smp_s_addr !== 32'h40) addr_bad = 1'b1;
            if (smp_m0_ack === 1'b1) bus.m0_req = 1'b0;
            if (smp_m1_ack === 1'b1) begin bus.m1_req = 1'b0; bus.grnt = 2'b00; end
            if (m1_start < 0 && smp_s_req === 1'b1 && smp_s_addr === 32'h30) m1_start = c;
        end
        total_cnt++;
        if (addr_bad) $display("FAIL toggle_addr_held act=changed exp=00000040");
        else pass_cnt++;
        total_cnt++;
        if (m1_start !== 6 + LAT) $display("FAIL toggle_m1_start act=%0d exp=%0d", m1_start, 6 + LAT);
        else pass_cnt++;
        idle_cycles(2);
    endtask

    task automatic test_req_drop();
        int ack_at = -1;
        bus.grnt = 2'b01; bus.m0_req = 1'b1; bus.m0_addr = 32'h88; bus.m0_we = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            bus.s_ack = (c == 5);
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL drop_model c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
            if (c == 1) begin bus.m0_req = 1'b0; bus.grnt = 2'b00; end
            if (c == 4) begin
                total_cnt++;
                if (smp_s_req !== 1'b1) $display("FAIL drop_s_req_held act=%b exp=1", smp_s_req);
                else pass_cnt++;
            end
            if (smp_m0_ack === 1'b1 && ack_at < 0) ack_at = c;
        end
        total_cnt++;
        if (ack_at !== 5 + LAT) $display("FAIL drop_ack_cycle act=%0d exp=%0d", ack_at, 5 + LAT);
        else pass_cnt++;
        idle_cycles(2);
    endtask

    task automatic test_illegal_grant();
        bus.grnt = 2'b11; bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        bus.m0_addr = 32'h50; bus.m1_addr = 32'h60;
        for (int c = 1; c <= 8; c++) begin
            bus.s_ack = (c == 3);
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL illegal_model c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
            if (c == 2) begin
                total_cnt++;
                if (smp_s_addr !== 32'h50 || smp_grnt_err !== 1'b1)
                    $display("FAIL illegal_capture addr=%h err=%b exp 50/1", smp_s_addr, smp_grnt_err);
                else pass_cnt++;
            end
            if (smp_m0_ack === 1'b1) drive_idle();
        end
        total_cnt++;
        if (smp_grnt_err !== 1'b1) $display("FAIL illegal_sticky act=%b exp=1", smp_grnt_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_busy();
        int ack_at = -1;
        bit early_ack = 1'b0;
        bus.grnt = 2'b01; bus.m0_req = 1'b1; bus.m0_addr = 32'h99;
        for (int c = 1; c <= 2; c++) begin
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL rstbusy_model c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
        end
        bus.s_ack = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if (bus.s_req !== 1'b0 || bus.busy !== 1'b0 || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0)
            $display("FAIL rstbusy_outputs req=%b busy=%b ack0=%b ack1=%b exp 0/0/0/0",
                     bus.s_req, bus.busy, bus.m0_ack, bus.m1_ack);
        else pass_cnt++;
        model_reset();
        drive_idle();
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.grnt = 2'b10; bus.m1_req = 1'b1; bus.m1_addr = 32'h70; bus.s_rdata = 32'h12345678;
        for (int c = 1; c <= 6; c++) begin
            bus.s_ack = (c == 3);
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL rstbusy_next c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
            if (smp_m0_ack === 1'b1) early_ack = 1'b1;
            if (smp_m1_ack === 1'b1 && ack_at < 0) begin
                ack_at = c; bus.m1_req = 1'b0; bus.grnt = 2'b00;
            end
        end
        total_cnt++;
        if (ack_at !== 3 + LAT || early_ack || smp_grnt_err !== 1'b0)
            $display("FAIL rstbusy_followup ack_at=%0d m0_ack=%b err=%b exp %0d/0/0",
                     ack_at, early_ack, smp_grnt_err, 3 + LAT);
        else pass_cnt++;
        idle_cycles(2);
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            bus.grnt     = (r == 0) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            bus.m0_req   = ($urandom_range(0, 9) < 7);
            bus.m1_req   = ($urandom_range(0, 9) < 7);
            bus.m0_addr  = $urandom; bus.m1_addr = $urandom;
            bus.m0_we    = $urandom_range(0, 1) == 1; bus.m1_we = $urandom_range(0, 1) == 1;
            bus.m0_wdata = $urandom; bus.m1_wdata = $urandom;
            bus.s_ack    = ($urandom_range(0, 9) < 3);
            bus.s_rdata  = $urandom;
            cycle(ev, av);
            total_cnt++;
            if (av !== ev) $display("FAIL random c%0d act=%h exp=%h", c, av, ev);
            else pass_cnt++;
        end
        idle_cycles(3);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_read_m1();
        test_grant_toggle();
        test_req_drop();
        test_illegal_grant();
        test_reset_mid_busy();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
